// File: rtl/interp_core.sv
// interp_core: multi-channel linear interpolator between the two most recent input strobes
// Ports: clk/reset (sync, active-high), run (low clears tick, counter and FSM),
//   din_en/din (strobe and CH signed samples), dout_valid/dout (CH signed results, one-cycle
//   valid pulse, held until the next update), busy (computation in progress).
// Optional macro INTERP_TEST_PORT_EN adds the registered 16-bit test_data debug port.
module interp_core #(
  parameter int DW = 24,
  parameter int CW = 11,
  parameter int CH = 2,
  parameter int OUT_DIV = 512
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      din_en,
  input  logic [CH*DW-1:0]          din,
  output logic                      dout_valid,
  output logic [CH*(DW+CW+1)-1:0]   dout,
  output logic                      busy
`ifdef INTERP_TEST_PORT_EN
  ,
  output logic [15:0]               test_data
`endif
);
  localparam int PW = DW + CW + 1;
  localparam int KW = CH > 1 ? $clog2(CH) : 1;
  localparam int TW = OUT_DIV > 1 ? $clog2(OUT_DIV) : 1;
  typedef enum logic [2:0] {IDLE, MUL1, MUL0, STORE, DONE} state_t;
  state_t r_state, w_next;
  logic [TW-1:0] r_tcnt;
  logic r_tick;
  logic [CW-1:0] r_sub, r_max, r_a, r_m;
  logic signed [DW-1:0] r_d0 [CH];
  logic signed [DW-1:0] r_d1 [CH];
  logic signed [DW-1:0] r_d0s [CH];
  logic signed [DW-1:0] r_d1s [CH];
  logic signed [PW-1:0] r_acc;
  logic signed [PW-1:0] r_sh [CH];
  logic [KW-1:0] r_k;
  logic w_start, w_last;
  logic signed [DW-1:0] w_ma;
  logic signed [CW:0] w_mb;
  logic signed [PW-1:0] w_prod;
  // A tick only starts a computation when the FSM is idle; a tick while busy is dropped.
  assign w_start = r_tick && run && r_state == IDLE;
  assign w_last = r_tcnt == TW'(OUT_DIV - 1);
  assign busy = r_state != IDLE;
  // Single shared multiplier: weights are non-negative, so they get a zero sign bit.
  assign w_ma = r_state == MUL1 ? r_d1s[r_k] : r_d0s[r_k];
  assign w_mb = r_state == MUL1 ? signed'({1'b0, r_m - r_a}) : signed'({1'b0, r_a});
  assign w_prod = PW'(w_ma) * PW'(w_mb);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? MUL1 : IDLE;
      MUL1:    w_next = MUL0;
      MUL0:    w_next = STORE;
      STORE:   w_next = r_k == KW'(CH - 1) ? DONE : MUL1;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (!run) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcnt <= '0;
      r_tick <= 1'b0;
      r_sub <= '0;
      r_max <= '0;
      r_a <= '0;
      r_m <= '0;
      r_acc <= '0;
      r_k <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        r_d0[i] <= '0;
        r_d1[i] <= '0;
        r_d0s[i] <= '0;
        r_d1s[i] <= '0;
        r_sh[i] <= '0;
      end
    end else begin
      r_tcnt <= !run || w_last ? '0 : r_tcnt + 1'b1;
      r_tick <= run && w_last;
      r_sub <= din_en ? '0 : r_sub != '1 ? r_sub + 1'b1 : r_sub;
      if (din_en) begin
        r_max <= r_sub;
        for (int i = 0; i < CH; i++) begin
          r_d1[i] <= r_d0[i];
          r_d0[i] <= din[i*DW +: DW];
        end
      end
      // Snapshot takes the pre-strobe values even if din_en coincides with the tick.
      if (w_start) begin
        r_a <= r_sub < r_max ? r_sub : r_max;
        r_m <= r_max;
        r_k <= '0;
        for (int i = 0; i < CH; i++) begin
          r_d0s[i] <= r_d0[i];
          r_d1s[i] <= r_d1[i];
        end
      end
      if (r_state == MUL1) r_acc <= w_prod;
      if (r_state == MUL0) r_acc <= r_acc + w_prod;
      if (r_state == STORE) begin
        r_sh[r_k] <= r_acc;
        r_k <= r_k + 1'b1;
      end
      // All channels leave the shadow registers together, so dout is never partially updated.
      dout_valid <= run && r_state == DONE;
      if (run && r_state == DONE)
        for (int i = 0; i < CH; i++) dout[i*PW +: PW] <= r_sh[i];
    end
  end
`ifdef INTERP_TEST_PORT_EN
  always_ff @(posedge clk) begin
    if (reset) test_data <= '0;
    else test_data <= {r_state, din_en, dout_valid, 11'(r_a)};
  end
`endif
endmodule

// File: tb/tb_interp_core.sv
// tb_interp_core: randomized self-checking bench for interp_core against a timestamp-based reference model
module tb_interp_core;
  localparam int DW = 24;
  localparam int CW = 11;
  localparam int CH = 2;
  localparam int OD = 512;
  localparam int PW = DW + CW + 1;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset, run, din_en;
  logic [CH*DW-1:0] din;
  logic dout_valid, busy;
  logic [CH*PW-1:0] dout;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int zero_at = 0;
  int run_from = 0;
  int valid_at = -1;
  int busy_from = 0;
  int busy_to = -1;
  int mmax = 0;
  longint m_d0 [CH];
  longint m_d1 [CH];
  longint e_pend [CH];
  longint e_dout [CH];
  interp_core #(.DW(DW), .CW(CW), .CH(CH), .OUT_DIV(OD)) dut (
    .clk(clk), .reset(reset), .run(run), .din_en(din_en), .din(din),
    .dout_valid(dout_valid), .dout(dout), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic longint dch(input int k);
    logic signed [PW-1:0] t;
    t = dout[k*PW +: PW];
    return longint'(t);
  endfunction
  function automatic logic [DW-1:0] rnd();
    int r;
    r = $urandom_range(0, 3);
    return r == 0 ? 24'h800000 : r == 1 ? 24'h7fffff : DW'($urandom);
  endfunction
  function automatic logic [CH*DW-1:0] pick(input int kind, input int i);
    if (kind == 0) return {24'd100, 24'd100};
    if (kind == 1) return {24'hfffffc, i == 0 ? 24'd0 : 24'd1};
    return {rnd(), rnd()};
  endfunction
  // Reference model: sub-count is elapsed cycles since the last strobe (saturating), ticks fall
  // every OD cycles after run became continuously active, result is weighted sum of the two samples.
  always @(posedge clk) begin : model
    int sub, a;
    logic signed [DW-1:0] t;
    cyc++;
    sub = cyc - zero_at > SAT ? SAT : cyc - zero_at;
    if (reset) begin
      zero_at = cyc + 1;
      run_from = cyc + 1;
      mmax = 0;
      if (busy_to >= cyc) busy_to = cyc;
      valid_at = -1;
      for (int k = 0; k < CH; k++) begin
        m_d0[k] = 0;
        m_d1[k] = 0;
        e_dout[k] = 0;
      end
    end else begin
      if (run && cyc > run_from && (cyc - run_from) % OD == 0 && busy_to < cyc) begin
        a = sub < mmax ? sub : mmax;
        for (int k = 0; k < CH; k++) e_pend[k] = m_d1[k] * (mmax - a) + m_d0[k] * a;
        busy_from = cyc + 1;
        busy_to = cyc + 3 * CH + 1;
        valid_at = cyc + 3 * CH + 2;
      end
      if (!run) begin
        run_from = cyc + 1;
        if (busy_to >= cyc) busy_to = cyc;
        valid_at = -1;
      end
      if (din_en) begin
        mmax = sub;
        for (int k = 0; k < CH; k++) begin
          m_d1[k] = m_d0[k];
          t = din[k*DW +: DW];
          m_d0[k] = longint'(t);
        end
        zero_at = cyc + 1;
      end
    end
  end
  always @(negedge clk) begin : scoreboard
    int cc;
    cc = cyc + 1;
    if (cc == valid_at) for (int k = 0; k < CH; k++) e_dout[k] = e_pend[k];
    if (dout_valid || cc == valid_at) check("dout_valid", dout_valid, cc == valid_at);
    if (cc == valid_at) begin
      check("dout_ch0", dch(0), e_dout[0]);
      check("dout_ch1", dch(1), e_dout[1]);
    end
    if (busy || (cc >= busy_from && cc <= busy_to + 1))
      check("busy", busy, cc >= busy_from && cc <= busy_to);
  end
  task automatic strobes(input int period, input int n, input int kind);
    for (int i = 0; i < n; i++) begin
      din_en = 1'b1;
      din = pick(kind, i);
      @(negedge clk);
      din_en = 1'b0;
      repeat (period - 1) @(negedge clk);
    end
  endtask
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!dout_valid && n < 1200) begin
      @(negedge clk);
      n++;
    end
    if (!dout_valid) check(tag, dout_valid, 1);
  endtask
  task automatic wait_busy_rise();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    while (!busy && n < 1200) begin
      @(negedge clk);
      n++;
    end
    if (!busy) check("busy_rise_timeout", busy, 1);
  endtask
  initial begin
    reset = 1'b1;
    run = 1'b0;
    din_en = 1'b0;
    din = '0;
    repeat (3) @(negedge clk);
    check("reset_dout", dch(0), 0);
    check("reset_valid", dout_valid, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    run = 1'b1;
    strobes(1024, 3, 0);
    wait_valid("const100_timeout");
    check("const100_ch0", dch(0), 102300);
    check("const100_ch1", dch(1), 102300);
    strobes(1024, 2, 1);
    wait_valid("ramp_timeout");
    check("ramp_ch1", dch(1), -4092);
    repeat (3000) @(negedge clk);
    wait_valid("sat_timeout");
    check("sat_ch0", dch(0), 1023);
    check("sat_ch1", dch(1), -4092);
    wait_valid("mzero_sync_timeout");
    strobes(1, 2, 2);
    wait_valid("mzero_timeout");
    check("mzero_ch0", dch(0), 0);
    check("mzero_ch1", dch(1), 0);
    for (int i = 0; i < 6; i++) strobes($urandom_range(1, 2500), $urandom_range(1, 3), 2);
    wait_busy_rise();
    repeat (OD - 1) @(negedge clk);
    din_en = 1'b1;
    din = pick(2, 0);
    @(negedge clk);
    din_en = 1'b0;
    wait_valid("coincide_timeout");
    @(negedge clk);
    wait_valid("coincide_next_timeout");
    wait_busy_rise();
    repeat (2) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    check("run_drop_busy", busy, 0);
    run = 1'b1;
    repeat (20) @(negedge clk);
    check("run_drop_hold_ch0", dch(0), e_dout[0]);
    check("run_drop_hold_ch1", dch(1), e_dout[1]);
    wait_busy_rise();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_reset_busy", busy, 0);
    check("abort_reset_ch0", dch(0), 0);
    check("abort_reset_ch1", dch(1), 0);
    strobes(700, 3, 2);
    wait_valid("final_timeout");
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
